// File: rtl/bus_arbiter_pkg.sv
// Shared types for the N-master word-bus arbiter.
// Master ids are sized for the largest supported arbiter; instances narrow them to $clog2(NUM_MASTERS).
package bus_arbiter_pkg;

  localparam int MAX_MASTERS = 16;
  localparam int MASTER_ID_W = $clog2(MAX_MASTERS);

  typedef logic [MASTER_ID_W-1:0] MasterId_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } ArbState_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin / fixed-priority picker: first requester at or after rr_ptr, wrapping.
// Zero latency; no state and no backpressure of its own.
module rr_priority_picker #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] rr_ptr,
  input  logic           fixed_prio,
  output logic [IDW-1:0] id,
  output logic           valid
);

  logic [2*N-1:0] dbl_req;
  logic [2*N-1:0] thresh;
  logic [2*N-1:0] masked;
  logic [IDW-1:0] start;

  // Two copies of req side by side turn the wrap-around search into a plain lowest-bit search.
  always_comb begin
    start   = fixed_prio ? '0 : rr_ptr;
    dbl_req = {req, req};
    thresh  = '0;
    for (int i = 0; i < 2*N; i++) begin
      thresh[i] = (i >= int'(start));
    end
    masked = dbl_req & thresh;
    id     = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (masked[i]) begin
        id = IDW'(i % N);
      end
    end
    valid = |req;
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-master to 1-slave word-bus arbiter; owner picked combinationally in IDLE (zero added latency).
// A stalled transfer locks the grant until it completes or the owner withdraws; losers see m_stall = 1.
module bus_arbiter_rr
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MASK_WIDTH     = DATA_WIDTH / 8,
  parameter int FIXED_PRIORITY = 0,
  localparam int ID_W          = $clog2(NUM_MASTERS)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address,
  input  logic [NUM_MASTERS-1:0]            m_read,
  input  logic [NUM_MASTERS-1:0]            m_write,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_wr,
  input  logic [NUM_MASTERS*MASK_WIDTH-1:0] m_mask,
  output logic [NUM_MASTERS-1:0]            m_stall,
  output logic [DATA_WIDTH-1:0]             m_data_rd,
  output logic [DATA_WIDTH-1:0]             m_data_rd_2,
  output logic [ADDR_WIDTH-1:0]             s_address,
  output logic                              s_read,
  output logic                              s_write,
  output logic [DATA_WIDTH-1:0]             s_data_wr,
  output logic [MASK_WIDTH-1:0]             s_mask,
  input  logic                              s_stall,
  input  logic [DATA_WIDTH-1:0]             s_data_rd,
  input  logic [DATA_WIDTH-1:0]             s_data_rd_2,
  output logic [ID_W-1:0]                   grant_id,
  output logic                              grant_valid
);

  ArbState_t             state_q, state_d;
  logic [ID_W-1:0]       lock_id_q, lock_id_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NUM_MASTERS-1:0] req;
  logic [ID_W-1:0]       pick_id;
  logic                  pick_vld;
  logic [ID_W-1:0]       owner;
  logic                  owner_vld;
  logic                  owner_req;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (int'(id) == NUM_MASTERS - 1) ? '0 : id + 1'b1;
  endfunction

  assign req = m_read | m_write;

  rr_priority_picker #(
    .N   (NUM_MASTERS),
    .IDW (ID_W)
  ) u_picker (
    .req        (req),
    .rr_ptr     (rr_ptr_q),
    .fixed_prio (FIXED_PRIORITY != 0),
    .id         (pick_id),
    .valid      (pick_vld)
  );

  // While rst_n is low there is no owner, which forces every output to its idle value.
  always_comb begin
    owner     = '0;
    owner_vld = 1'b0;
    if (rst_n) begin
      if (state_q == ARB_LOCKED) begin
        owner     = lock_id_q;
        owner_vld = 1'b1;
      end else if (pick_vld) begin
        owner     = pick_id;
        owner_vld = 1'b1;
      end
    end
    owner_req = owner_vld & req[owner];
  end

  always_comb begin
    s_read    = owner_vld & m_read[owner];
    s_write   = owner_vld & m_write[owner];
    s_address = '0;
    s_data_wr = '0;
    s_mask    = '0;
    if (owner_vld) begin
      s_address = m_address[int'(owner)*ADDR_WIDTH +: ADDR_WIDTH];
      s_data_wr = m_data_wr[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
      s_mask    = m_mask[int'(owner)*MASK_WIDTH +: MASK_WIDTH];
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_stall[i] = rst_n & req[i] &
                   ((owner_vld && owner == ID_W'(i)) ? s_stall : 1'b1);
    end
    m_data_rd   = s_data_rd;
    m_data_rd_2 = s_data_rd_2;
    grant_valid = owner_vld;
    grant_id    = owner;
  end

  // Completion and withdrawal both release the lock; re-arbitration waits for the next cycle.
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    rr_ptr_d  = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          if (s_stall) begin
            state_d   = ARB_LOCKED;
            lock_id_d = pick_id;
          end else begin
            rr_ptr_d = next_id(pick_id);
          end
        end
      end
      ARB_LOCKED: begin
        if (!owner_req || !s_stall) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = next_id(lock_id_q);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      lock_id_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: a round-robin and a fixed-priority instance share stimulus;
// a queue-based scoreboard checks both against a behavioural model, plus directed checks.
module tb_bus_arbiter_rr;

  logic         clk;
  logic         rst_n;
  logic [3:0]   m_read, m_write;
  logic [127:0] m_address, m_data_wr;
  logic [15:0]  m_mask;
  logic         s_stall;
  logic [31:0]  s_data_rd, s_data_rd_2;

  logic [3:0]  r_stall, f_stall;
  logic [31:0] r_drd, r_drd2, r_addr, r_wd, f_drd, f_drd2, f_addr, f_wd;
  logic        r_rd, r_wr, r_gv, f_rd, f_wr, f_gv;
  logic [3:0]  r_mask, f_mask;
  logic [1:0]  r_gid, f_gid;

  bus_arbiter_rr #(.NUM_MASTERS(4), .FIXED_PRIORITY(0)) dut (
    .clk(clk), .rst_n(rst_n), .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_data_wr(m_data_wr), .m_mask(m_mask), .m_stall(r_stall), .m_data_rd(r_drd),
    .m_data_rd_2(r_drd2), .s_address(r_addr), .s_read(r_rd), .s_write(r_wr),
    .s_data_wr(r_wd), .s_mask(r_mask), .s_stall(s_stall), .s_data_rd(s_data_rd),
    .s_data_rd_2(s_data_rd_2), .grant_id(r_gid), .grant_valid(r_gv)
  );

  bus_arbiter_rr #(.NUM_MASTERS(4), .FIXED_PRIORITY(1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_data_wr(m_data_wr), .m_mask(m_mask), .m_stall(f_stall), .m_data_rd(f_drd),
    .m_data_rd_2(f_drd2), .s_address(f_addr), .s_read(f_rd), .s_write(f_wr),
    .s_data_wr(f_wd), .s_mask(f_mask), .s_stall(s_stall), .s_data_rd(s_data_rd),
    .s_data_rd_2(s_data_rd_2), .grant_id(f_gid), .grant_valid(f_gv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          inst;
    logic        gv;
    logic [1:0]  gid;
    logic        rd, wr;
    logic [31:0] addr, wd, drd, drd2;
    logic [3:0]  mask, stall;
    logic [1:0]  ptr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   mdl_lock[2];
  int   mdl_ptr[2];
  int   seq[6] = '{0, 1, 3, 0, 1, 3};
  logic [3:0] exp_stall;

  task automatic chk(string name, logic [31:0] got, logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, expv, $time);
    end
  endtask

  // Reference model: owner is the locked master, else the first requester scanning from the pointer.
  function automatic int pick(int inst);
    logic [3:0] rq;
    rq = m_read | m_write;
    if (mdl_lock[inst] >= 0) return mdl_lock[inst];
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (inst == 1) ? k : (mdl_ptr[inst] + k) % 4;
      if (rq[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic void push_exp(int inst);
    exp_t e;
    int o;
    logic [3:0] rq;
    rq = m_read | m_write;
    o = rst_n ? pick(inst) : -1;
    e.inst = inst;
    e.gv   = (o >= 0);
    e.gid  = (o >= 0) ? 2'(o) : 2'd0;
    e.rd   = (o >= 0) && m_read[o];
    e.wr   = (o >= 0) && m_write[o];
    e.addr = (o >= 0) ? m_address[o*32 +: 32] : 32'd0;
    e.wd   = (o >= 0) ? m_data_wr[o*32 +: 32] : 32'd0;
    e.mask = (o >= 0) ? m_mask[o*4 +: 4] : 4'd0;
    for (int i = 0; i < 4; i++) begin
      e.stall[i] = rst_n && rq[i] && ((i == o) ? s_stall : 1'b1);
    end
    e.drd  = s_data_rd;
    e.drd2 = s_data_rd_2;
    e.ptr  = 2'(mdl_ptr[inst]);
    exp_q.push_back(e);
  endfunction

  function automatic void update_model(int inst);
    int o;
    logic [3:0] rq;
    rq = m_read | m_write;
    if (!rst_n) begin
      mdl_lock[inst] = -1;
      mdl_ptr[inst]  = 0;
    end else if (mdl_lock[inst] >= 0) begin
      if (!rq[mdl_lock[inst]] || !s_stall) begin
        mdl_ptr[inst]  = (mdl_lock[inst] + 1) % 4;
        mdl_lock[inst] = -1;
      end
    end else begin
      o = pick(inst);
      if (o >= 0) begin
        if (s_stall) mdl_lock[inst] = o;
        else         mdl_ptr[inst]  = (o + 1) % 4;
      end
    end
  endfunction

  task automatic step();
    push_exp(0);
    push_exp(1);
    @(posedge clk);
    update_model(0);
    update_model(1);
    #1;
  endtask

  task automatic clr();
    m_read  = '0;
    m_write = '0;
    s_stall = 1'b0;
  endtask

  task automatic set_m(int i, logic rd, logic wr, logic [31:0] a, logic [31:0] d, logic [3:0] mk);
    m_read[i]            = rd;
    m_write[i]           = wr;
    m_address[i*32 +: 32] = a;
    m_data_wr[i*32 +: 32] = d;
    m_mask[i*4 +: 4]      = mk;
  endtask

  always @(negedge clk) begin
    while (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e.inst == 0) begin
        chk("rr_grant_valid", r_gv, mon_e.gv);
        chk("rr_grant_id", r_gid, mon_e.gid);
        chk("rr_s_read", r_rd, mon_e.rd);
        chk("rr_s_write", r_wr, mon_e.wr);
        chk("rr_s_address", r_addr, mon_e.addr);
        chk("rr_s_data_wr", r_wd, mon_e.wd);
        chk("rr_s_mask", r_mask, mon_e.mask);
        chk("rr_m_stall", r_stall, mon_e.stall);
        chk("rr_m_data_rd", r_drd, mon_e.drd);
        chk("rr_m_data_rd_2", r_drd2, mon_e.drd2);
        chk("rr_ptr", dut.rr_ptr_q, mon_e.ptr);
      end else begin
        chk("fp_grant_valid", f_gv, mon_e.gv);
        chk("fp_grant_id", f_gid, mon_e.gid);
        chk("fp_s_read", f_rd, mon_e.rd);
        chk("fp_s_write", f_wr, mon_e.wr);
        chk("fp_s_address", f_addr, mon_e.addr);
        chk("fp_s_data_wr", f_wd, mon_e.wd);
        chk("fp_s_mask", f_mask, mon_e.mask);
        chk("fp_m_stall", f_stall, mon_e.stall);
        chk("fp_m_data_rd", f_drd, mon_e.drd);
      end
    end
  end

  initial begin
    mdl_lock[0] = -1; mdl_lock[1] = -1;
    mdl_ptr[0]  = 0;  mdl_ptr[1]  = 0;
    rst_n = 1'b0;
    clr();
    m_address = '0; m_data_wr = '0; m_mask = '0;
    s_data_rd = 32'h1234_5678; s_data_rd_2 = 32'h9abc_def0;
    @(posedge clk); #1;
    set_m(1, 1'b1, 1'b0, 32'h55, 32'h66, 4'hf);
    #1;
    chk("reset_grant_valid", r_gv, 1'b0);
    chk("reset_m_stall", r_stall, 4'h0);
    step();
    rst_n = 1'b1;
    clr();

    // Lone master sees the slave directly.
    set_m(2, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hf);
    #1;
    chk("single_s_read", r_rd, 1'b1);
    chk("single_s_address", r_addr, 32'h1000);
    chk("single_m_stall2", r_stall[2], 1'b0);
    step();
    chk("single_rr_ptr", dut.rr_ptr_q, 2'd3);
    clr();

    // Round-robin contention from a fresh pointer.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    set_m(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hf);
    set_m(1, 1'b1, 1'b0, 32'h200, 32'h0, 4'hf);
    set_m(3, 1'b1, 1'b0, 32'h300, 32'h0, 4'hf);
    for (int k = 0; k < 6; k++) begin
      #1;
      exp_stall = 4'b1011 & ~(4'b0001 << seq[k]);
      chk("rr_seq_grant", r_gid, seq[k]);
      chk("rr_seq_stall", r_stall, exp_stall);
      step();
    end
    clr();

    // Grant held across a stalled write.
    set_m(1, 1'b0, 1'b1, 32'h400, 32'hDEAD_BEEF, 4'b0011);
    for (int k = 0; k < 4; k++) begin
      s_stall = (k < 3);
      if (k == 1) set_m(0, 1'b1, 1'b0, 32'h2000, 32'h0, 4'hf);
      #1;
      chk("lock_grant", r_gid, 2'd1);
      chk("lock_data_wr", r_wd, 32'hDEAD_BEEF);
      chk("lock_mask", r_mask, 4'b0011);
      step();
    end
    m_write[1] = 1'b0;
    #1;
    chk("lock_next_grant", r_gid, 2'd0);
    step();
    clr();

    // Owner withdraws while locked.
    set_m(2, 1'b1, 1'b0, 32'h500, 32'h0, 4'hf);
    s_stall = 1'b1;
    step();
    m_read[2] = 1'b0;
    #1;
    chk("abort_s_read", r_rd, 1'b0);
    chk("abort_grant_valid", r_gv, 1'b1);
    step();
    #1;
    chk("abort_idle", r_gv, 1'b0);
    chk("abort_rr_ptr", dut.rr_ptr_q, 2'd3);
    step();

    // Reset while locked drops the lock.
    m_read[2] = 1'b1;
    step();
    rst_n = 1'b0;
    step();
    #1;
    chk("rst_grant_valid", r_gv, 1'b0);
    chk("rst_s_read", r_rd, 1'b0);
    chk("rst_s_address", r_addr, 32'h0);
    step();
    rst_n = 1'b1;
    s_stall = 1'b0;
    set_m(0, 1'b1, 1'b0, 32'h600, 32'h0, 4'hf);
    #1;
    chk("rst_release_grant", r_gid, 2'd0);
    step();
    clr();

    // Pointer wrap from master 3 back to master 0.
    set_m(2, 1'b1, 1'b0, 32'h700, 32'h0, 4'hf);
    step();
    clr();
    set_m(3, 1'b1, 1'b0, 32'h800, 32'h0, 4'hf);
    set_m(0, 1'b1, 1'b0, 32'h900, 32'h0, 4'hf);
    #1;
    chk("wrap_grant3", r_gid, 2'd3);
    step();
    #1;
    chk("wrap_grant0", r_gid, 2'd0);
    step();
    chk("wrap_rr_ptr", dut.rr_ptr_q, 2'd1);

    // Fixed priority: master 0 always wins, master 3 starves.
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("fp_grant", f_gid, 2'd0);
      chk("fp_starve_stall3", f_stall[3], 1'b1);
      step();
    end
    clr();

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        int r;
        r = $urandom_range(0, 3);
        set_m(i, r == 1, r == 2, $urandom, $urandom, 4'($urandom));
      end
      s_stall     = ($urandom_range(0, 9) < 3);
      rst_n       = ($urandom_range(0, 99) != 0);
      s_data_rd   = $urandom;
      s_data_rd_2 = $urandom;
      step();
    end
    rst_n = 1'b1;
    clr();
    step();
    @(negedge clk); #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
